// File: rtl/video_timing_gen_prog.sv
// Programmable raster timing generator: coordinates, active, syncs and line/frame strobes.
// New timing is staged in a shadow copy and takes effect only at a frame boundary.
module video_timing_gen_prog #(
    parameter int unsigned CW         = 11,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned H_RES_PIX  = 640,
    parameter int unsigned H_FN_PRCH  = 32,
    parameter int unsigned H_SYNC_PW  = 88,
    parameter int unsigned H_BK_PRCH  = 32,
    parameter int unsigned V_RES_PIX  = 480,
    parameter int unsigned V_FN_PRCH  = 10,
    parameter int unsigned V_SYNC_PW  = 5,
    parameter int unsigned V_BK_PRCH  = 10,
    parameter int unsigned H_SYNC_POL = 0,
    parameter int unsigned V_SYNC_POL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_load,
    input  logic [CW-1:0] cfg_h_act,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sw,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_act,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sw,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_h_pol,
    input  logic          cfg_v_pol,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          active,
    output logic          h_sync,
    output logic          v_sync,
    output logic          preload_line,
    output logic          line_start,
    output logic          frame_start
);
    localparam int unsigned TW = CW + 2;

    typedef struct packed {
        logic [CW-1:0] h_act;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sw;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_act;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sw;
        logic [CW-1:0] v_bp;
        logic          h_pol;
        logic          v_pol;
    } cfg_t;

    typedef struct packed {
        logic [TW-1:0] htot;
        logic [TW-1:0] hs_beg;
        logic [TW-1:0] hs_end;
        logic [TW-1:0] vtot;
        logic [TW-1:0] vs_beg;
        logic [TW-1:0] vs_end;
    } tim_t;

    localparam cfg_t CfgDef = '{
        h_act: CW'(H_RES_PIX), h_fp: CW'(H_FN_PRCH), h_sw: CW'(H_SYNC_PW), h_bp: CW'(H_BK_PRCH),
        v_act: CW'(V_RES_PIX), v_fp: CW'(V_FN_PRCH), v_sw: CW'(V_SYNC_PW), v_bp: CW'(V_BK_PRCH),
        h_pol: 1'(H_SYNC_POL), v_pol: 1'(V_SYNC_POL)
    };
    localparam logic [TW-1:0] MaxTot = {2'b01, {CW{1'b0}}};

    function automatic logic [TW-1:0] ext(input logic [CW-1:0] v);
        return {2'b00, v};
    endfunction

    function automatic tim_t derive(input cfg_t c);
        tim_t t;
        t.hs_beg = ext(c.h_act) + ext(c.h_fp);
        t.hs_end = t.hs_beg + ext(c.h_sw);
        t.htot   = t.hs_end + ext(c.h_bp);
        t.vs_beg = ext(c.v_act) + ext(c.v_fp);
        t.vs_end = t.vs_beg + ext(c.v_sw);
        t.vtot   = t.vs_end + ext(c.v_bp);
        return t;
    endfunction

    cfg_t          cfg_q, sh_q, sh_d, in_cfg;
    tim_t          tim_q;
    logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic          cfg_pending_q, pending_d, cfg_err_q;
    logic [TW-1:0] hcnt_x, vcnt_x, v_next, in_htot, in_vtot;
    logic          run, h_last, v_last, do_apply, cfg_valid, load_ok;
    logic          act_raw, hs_raw, vs_raw;
    logic [2:0]    dly_raw, dly_out;

    assign in_cfg = '{
        h_act: cfg_h_act, h_fp: cfg_h_fp, h_sw: cfg_h_sw, h_bp: cfg_h_bp,
        v_act: cfg_v_act, v_fp: cfg_v_fp, v_sw: cfg_v_sw, v_bp: cfg_v_bp,
        h_pol: cfg_h_pol, v_pol: cfg_v_pol
    };
    assign in_htot = ext(cfg_h_act) + ext(cfg_h_fp) + ext(cfg_h_sw) + ext(cfg_h_bp);
    assign in_vtot = ext(cfg_v_act) + ext(cfg_v_fp) + ext(cfg_v_sw) + ext(cfg_v_bp);
    assign cfg_valid = (cfg_h_act != '0) && (cfg_h_fp != '0) && (cfg_h_sw != '0)
                    && (cfg_h_bp != '0) && (cfg_v_act != '0) && (cfg_v_fp != '0)
                    && (cfg_v_sw != '0) && (cfg_v_bp != '0)
                    && (in_htot <= MaxTot) && (in_vtot <= MaxTot);
    assign load_ok = cfg_load && cfg_valid;

    assign hcnt_x   = ext(hcnt_q);
    assign vcnt_x   = ext(vcnt_q);
    assign h_last   = (hcnt_x == tim_q.htot - TW'(1));
    assign v_last   = (vcnt_x == tim_q.vtot - TW'(1));
    assign v_next   = v_last ? '0 : vcnt_x + TW'(1);
    // Idle generator may switch mode at once; a running one only on the last pixel of a frame.
    assign do_apply = cfg_pending_q && (!en || (h_last && v_last));

    always_comb begin
        hcnt_d = hcnt_q + CW'(1);
        vcnt_d = vcnt_q;
        if (!en) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
        end
    end

    always_comb begin
        sh_d      = sh_q;
        pending_d = cfg_pending_q;
        if (do_apply) pending_d = 1'b0;
        if (load_ok) begin
            sh_d      = in_cfg;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q         <= CfgDef;
            sh_q          <= CfgDef;
            tim_q         <= derive(CfgDef);
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            cfg_pending_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            sh_q          <= sh_d;
            cfg_pending_q <= pending_d;
            cfg_err_q     <= cfg_load && !cfg_valid;
            if (do_apply) begin
                cfg_q <= sh_q;
                tim_q <= derive(sh_q);
            end
        end
    end

    // Strobes and raw flags are forced idle while held in reset or disabled.
    assign run     = en & rst_n;
    assign act_raw = run && (hcnt_x < ext(cfg_q.h_act)) && (vcnt_x < ext(cfg_q.v_act));
    assign hs_raw  = run && (hcnt_x >= tim_q.hs_beg) && (hcnt_x < tim_q.hs_end);
    assign vs_raw  = run && (vcnt_x >= tim_q.vs_beg) && (vcnt_x < tim_q.vs_end);
    assign dly_raw = {act_raw, hs_raw, vs_raw};

    generate
        if (LATENCY == 0) begin : g_nodly
            assign dly_out = dly_raw;
        end else begin : g_dly
            logic [2:0] pipe_q [LATENCY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
                end else if (!en) begin
                    for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= dly_raw;
                    for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign dly_out = pipe_q[LATENCY-1];
        end
    endgenerate

    assign active       = run & dly_out[2];
    assign h_sync       = (run & dly_out[1]) ? cfg_q.h_pol : ~cfg_q.h_pol;
    assign v_sync       = (run & dly_out[0]) ? cfg_q.v_pol : ~cfg_q.v_pol;
    assign preload_line = run && (hcnt_x == ext(cfg_q.h_act)) && (v_next < ext(cfg_q.v_act));
    assign line_start   = run && (hcnt_q == '0);
    assign frame_start  = line_start && (vcnt_q == '0);
    assign hpos         = hcnt_q;
    assign vpos         = vcnt_q;
    assign cfg_pending  = cfg_pending_q;
    assign cfg_err      = cfg_err_q;
endmodule

// File: doc/video_timing_gen_prog.md
Name: video_timing_gen_prog

Overview:
- Programmable raster timing generator. It is the parametrised successor to the fixed-resolution timing inside the DVI transmitter.
- Produces pixel coordinates, the active flag, h/v sync, line-preload and frame/line-start strobes from a single pixel clock.
- Timing can be reloaded at runtime. A new config is applied only at a frame boundary, so the output never tears.
- Sits between the pixel-clock domain and the TMDS encoder/serialiser, and drives the line-buffer read logic of the background-subtractor display path.

Parameters:
- CW, 11, width of coordinate counters and config fields.
- LATENCY, 1, data-read latency in clocks (0..7); delay applied to active/h_sync/v_sync relative to hpos/vpos.
- H_RES_PIX, 640, reset-default horizontal active pixels.
- H_FN_PRCH, 32, reset-default horizontal front porch.
- H_SYNC_PW, 88, reset-default horizontal sync width.
- H_BK_PRCH, 32, reset-default horizontal back porch.
- V_RES_PIX, 480, reset-default vertical active lines.
- V_FN_PRCH, 10, reset-default vertical front porch.
- V_SYNC_PW, 5, reset-default vertical sync width.
- V_BK_PRCH, 10, reset-default vertical back porch.
- H_SYNC_POL, 0, reset-default h polarity (0 = active-low).
- V_SYNC_POL, 0, reset-default v polarity (0 = active-low).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- cfg_load  in  1  one-cycle request to latch all cfg_* inputs.
- cfg_h_act, cfg_h_fp, cfg_h_sw, cfg_h_bp  in  CW each  horizontal timing.
- cfg_v_act, cfg_v_fp, cfg_v_sw, cfg_v_bp  in  CW each  vertical timing.
- cfg_h_pol, cfg_v_pol  in  1 each  sync polarity.
- cfg_pending  out  1  shadow config waiting for frame boundary.
- cfg_err  out  1  one-cycle pulse: cfg_load rejected.
- hpos, vpos  out  CW each  current raw counters (read address).
- active  out  1  active pixel, delayed LATENCY clocks.
- h_sync, v_sync  out  1 each  syncs with polarity applied, delayed LATENCY clocks.
- preload_line  out  1  one-cycle pulse to prefetch the next active line.
- line_start  out  1  one-cycle pulse at hcnt==0.
- frame_start  out  1  one-cycle pulse at hcnt==0, vcnt==0.

Behaviour:
- Reset state:
  - Working and shadow configs load from the parameters.
  - hcnt and vcnt are 0.
  - All pulse outputs are 0; active is 0; cfg_pending is 0.
  - h_sync and v_sync sit at their deasserted level (= ~active level; 1 when POL=0).
  - The delay pipeline is filled with the inactive values.
- Region order per line: active [0, ACT), front porch, sync, back porch. htotal = act+fp+sw+bp. The same order applies vertically.
- Arithmetic: totals are computed at CW+2 bits and fixed when the config is applied. The CW-bit counters wrap from total-1 to 0.
- en=0: hcnt and vcnt are held at 0. active and strobes are 0; syncs are deasserted; the pipeline is flushed to inactive. The first clock with en=1 emits frame_start and line_start with hpos=vpos=0.
- Counting: hcnt increments every clock. At hcnt==htotal-1, hcnt wraps and vcnt increments, wrapping at vtotal-1.
- active_raw = (hcnt<h_act) && (vcnt<v_act).
- hsync_raw is asserted for hcnt in [h_act+h_fp, h_act+h_fp+h_sw).
- vsync_raw is asserted for vcnt in the corresponding vertical window, for whole lines (changes at hcnt==0).
- active_raw, hsync_raw and vsync_raw pass through a LATENCY-stage register delay. LATENCY=0 means the raw values drive the outputs combinationally.
- hpos and vpos are undelayed.
- preload_line: pulses when hcnt==h_act and the next line index ((vcnt+1) mod vtotal) is < v_act. This gives one pulse per active line, including the pulse for line 0 during the last blanking line.
- line_start and frame_start are undelayed.
- Config:
  - On cfg_load, validate: every field ≠ 0 and both totals ≤ 2^CW.
  - If valid: copy the fields to the shadow and set cfg_pending=1.
  - If invalid: pulse cfg_err the next cycle; shadow and pending are unchanged.
  - Apply shadow→working on the clock where hcnt==htotal-1 and vcnt==vtotal-1 (or immediately when en=0), then clear cfg_pending. The next cycle is frame 0 of the new mode.
  - cfg_load arriving in the same cycle as the apply: the old shadow is applied, the new values are latched, and cfg_pending stays 1.
  - A repeated cfg_load while pending overwrites the shadow.
- Asserting rst_n low mid-frame returns all state to reset values immediately; no partial-frame completion.

Test Plan:
- Defaults, LATENCY=1, en=1 for 2 frames:
  - line_start period is 792 clocks; frame_start period is 792×505 = 399960.
  - h_sync is low for hcnt 672..759, observed one clock later.
  - active has 640×480 high cycles per frame.
- preload_line check:
  - Exactly 480 pulses per frame, each at hcnt=640.
  - One of them falls on vcnt=504.
  - No pulse on vcnt=479..503.
- cfg_load mid-frame with 800/40/128/88 horizontal, 600/1/4/23 vertical, pol=1:
  - cfg_pending stays 1 until the old frame ends.
  - The next frame has htotal=1056, vtotal=628, and h_sync active-high.
- cfg_load with cfg_h_sw=0:
  - cfg_err pulses for 1 cycle; cfg_pending stays 0; timing is unchanged.
- LATENCY=3:
  - active rises exactly 3 clocks after hpos=0, vpos=0.
  - Sweep LATENCY=0: active and hpos are coincident.
- rst_n low at hcnt=300, vcnt=200:
  - Outputs go immediately to reset values.
  - After release, frame_start is asserted on the first clock; en toggling low re-zeros the counters.
